// File: rtl/target_scheduler_pkg.sv
// Shared definitions for the target game controllers.
//   NUM_TARGETS_DEF  default number of target slots (max 16)
//   IDX_W            width of a slot index
//   TICK_CYCLES_DEF  clock cycles per game tick (0.5 s at 50 MHz)
//   state_e          scheduler FSM encoding
//   wrap_inc()       slot index increment that wraps at a given last slot
package target_scheduler_pkg;

  localparam int NUM_TARGETS_DEF = 10;
  localparam int IDX_W           = 4;
  localparam int TICK_CYCLES_DEF = 25_000_000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROBE = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  // Wraps at the real slot count rather than at 2**IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] last);
    return (idx == last) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/target_scheduler_tick_divider.sv
// tick_divider: free-running period timer for game ticks.
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset, counter back to 0
//   i_enable  counter advances only while high
//   o_tick    high for the single enabled cycle in which the counter sits at
//             TICK_CYCLES-1; the counter wraps to 0 on that same cycle
module tick_divider
  import target_scheduler_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign o_tick = i_enable && w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_last ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/target_scheduler.sv
// target_scheduler: turns the random 0..15 index into a live field of targets.
// Each game tick places one target, linearly probing from the random index
// past busy slots; targets age per tick, hits score, expiries count as misses,
// and reaching MAX_MISSES ends the game until reset.
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_enable       game running; low pauses every piece of state
//   i_ran_num_ten  random slot index (values >= NUM_TARGETS skip the spawn)
//   i_hit_req      per-slot strike pulses, any number of bits at once
//   o_active_mask  bit i set while slot i holds a live target
//   o_spawn_pulse  one-cycle pulse when a target is placed
//   o_spawn_idx    slot of the latest placement (holds between pulses)
//   o_score        hit count, starts at 1 so the RNG modulus is never 0
//   o_misses       expired targets, saturates at MAX_MISSES
//   o_game_over    sticky end-of-game flag
//
// state    | meaning
// ST_RUN   | idle; on a tick tries the random slot directly
// ST_PROBE | walking forward one slot per cycle looking for a free slot
// ST_OVER  | game finished, everything frozen until reset
module target_scheduler
  import target_scheduler_pkg::*;
#(
  parameter int NUM_TARGETS    = NUM_TARGETS_DEF,
  parameter int TICK_CYCLES    = TICK_CYCLES_DEF,
  parameter int LIFETIME_TICKS = 4,
  parameter int MAX_ACTIVE     = 3,
  parameter int MAX_MISSES     = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [IDX_W-1:0]       i_ran_num_ten,
  input  logic [NUM_TARGETS-1:0] i_hit_req,
  output logic [NUM_TARGETS-1:0] o_active_mask,
  output logic                   o_spawn_pulse,
  output logic [IDX_W-1:0]       o_spawn_idx,
  output logic [31:0]            o_score,
  output logic [7:0]             o_misses,
  output logic                   o_game_over
);

  localparam int               LW        = $clog2(LIFETIME_TICKS + 1);
  localparam logic [LW-1:0]    LIFE_INIT = LW'(LIFETIME_TICKS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TARGETS - 1);
  localparam logic [IDX_W:0]   NUM_T     = (IDX_W + 1)'(NUM_TARGETS);
  localparam logic [IDX_W:0]   MAX_ACT   = (IDX_W + 1)'(MAX_ACTIVE);
  localparam logic [8:0]       MAX_MISS9 = 9'(MAX_MISSES);

  state_e                 r_state;
  logic [NUM_TARGETS-1:0] r_active_mask;
  logic [LW-1:0]          r_life [NUM_TARGETS];
  logic [IDX_W-1:0]       r_probe_idx;
  logic [IDX_W-1:0]       r_probes;
  logic                   r_spawn_pulse;
  logic [IDX_W-1:0]       r_spawn_idx;
  logic [31:0]            r_score;
  logic [7:0]             r_misses;
  logic                   r_game_over;

  logic                   w_run;
  logic                   w_tick;
  logic [NUM_TARGETS-1:0] w_hit;
  logic [NUM_TARGETS-1:0] w_exp;
  logic [IDX_W:0]         w_active_cnt;
  logic [IDX_W:0]         w_hit_cnt;
  logic [IDX_W:0]         w_exp_cnt;
  logic                   w_try;
  logic [IDX_W-1:0]       w_cand;
  logic [IDX_W-1:0]       w_cand_probes;
  logic                   w_cand_busy;
  logic                   w_spawn;
  logic [NUM_TARGETS-1:0] w_mask_nxt;
  logic [LW-1:0]          w_life_nxt [NUM_TARGETS];
  logic [32:0]            w_score_sum;
  logic [31:0]            w_score_nxt;
  logic [8:0]             w_miss_sum;
  logic [7:0]             w_misses_nxt;
  logic                   w_over_nxt;

  // Pausing or game over freezes the tick timer along with everything else.
  assign w_run = i_enable && (r_state != ST_OVER);

  tick_divider #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_divider (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (w_run),
    .o_tick   (w_tick)
  );

  // Strikes on empty slots are dropped here, so they never score or penalise.
  assign w_hit = w_run ? (i_hit_req & r_active_mask) : '0;

  always_comb begin
    w_active_cnt = '0;
    w_hit_cnt    = '0;
    w_exp_cnt    = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      w_active_cnt = w_active_cnt + (IDX_W + 1)'(r_active_mask[i]);
      w_hit_cnt    = w_hit_cnt + (IDX_W + 1)'(w_hit[i]);
      w_exp_cnt    = w_exp_cnt + (IDX_W + 1)'(w_exp[i]);
    end
  end

  // The first probe happens in the tick cycle itself, so an immediate free
  // slot spawns one cycle after the tick and each busy slot adds one cycle.
  always_comb begin
    w_try         = 1'b0;
    w_cand        = r_probe_idx;
    w_cand_probes = r_probes;
    if (w_run) begin
      if (r_state == ST_PROBE) begin
        w_try = 1'b1;
      end else if (w_tick && ({1'b0, i_ran_num_ten} < NUM_T)
                   && (w_active_cnt < MAX_ACT)) begin
        w_try         = 1'b1;
        w_cand        = i_ran_num_ten;
        w_cand_probes = '0;
      end
    end
    // Busy is judged on the mask before this cycle's hits and expiries.
    w_cand_busy = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (w_cand == IDX_W'(i)) begin
        w_cand_busy = r_active_mask[i];
      end
    end
  end

  assign w_spawn = w_try && !w_cand_busy;

  // Per-slot update: a hit beats an expiry in the same cycle, and a spawn can
  // only land on a slot that was already free, so it never meets a hit.
  always_comb begin
    w_mask_nxt = r_active_mask;
    w_life_nxt = r_life;
    w_exp      = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (w_hit[i]) begin
        w_mask_nxt[i] = 1'b0;
        w_life_nxt[i] = '0;
      end else if (w_tick && r_active_mask[i]) begin
        if (r_life[i] == LW'(1)) begin
          w_mask_nxt[i] = 1'b0;
          w_life_nxt[i] = '0;
          w_exp[i]      = 1'b1;
        end else begin
          w_life_nxt[i] = r_life[i] - LW'(1);
        end
      end
      if (w_spawn && (w_cand == IDX_W'(i))) begin
        w_mask_nxt[i] = 1'b1;
        w_life_nxt[i] = LIFE_INIT;
      end
    end
  end

  always_comb begin
    w_score_sum  = {1'b0, r_score} + 33'(w_hit_cnt);
    w_score_nxt  = w_score_sum[32] ? '1 : w_score_sum[31:0];
    w_miss_sum   = {1'b0, r_misses} + 9'(w_exp_cnt);
    w_misses_nxt = (w_miss_sum >= MAX_MISS9) ? 8'(MAX_MISSES) : w_miss_sum[7:0];
    w_over_nxt   = (w_misses_nxt == 8'(MAX_MISSES));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_active_mask <= '0;
      r_life        <= '{default: '0};
      r_probe_idx   <= '0;
      r_probes      <= '0;
      r_spawn_pulse <= 1'b0;
      r_spawn_idx   <= '0;
      r_score       <= 32'd1;
      r_misses      <= '0;
      r_game_over   <= 1'b0;
    end else begin
      r_spawn_pulse <= 1'b0;
      if (w_run) begin
        r_active_mask <= w_mask_nxt;
        r_life        <= w_life_nxt;
        r_score       <= w_score_nxt;
        r_misses      <= w_misses_nxt;
        case (r_state)
          ST_RUN, ST_PROBE: begin
            if (w_try) begin
              if (!w_cand_busy) begin
                r_spawn_pulse <= 1'b1;
                r_spawn_idx   <= w_cand;
                r_state       <= ST_RUN;
              end else if (w_cand_probes == LAST_IDX) begin
                // Every slot was seen busy: give up on this tick.
                r_state <= ST_RUN;
              end else begin
                r_state     <= ST_PROBE;
                r_probe_idx <= wrap_inc(w_cand, LAST_IDX);
                r_probes    <= w_cand_probes + IDX_W'(1);
              end
            end
          end
          default: ;
        endcase
        // Last activity cycle still completes; the freeze starts next cycle.
        if (w_over_nxt) begin
          r_state     <= ST_OVER;
          r_game_over <= 1'b1;
        end
      end
    end
  end

  assign o_active_mask = r_active_mask;
  assign o_spawn_pulse = r_spawn_pulse;
  assign o_spawn_idx   = r_spawn_idx;
  assign o_score       = r_score;
  assign o_misses      = r_misses;
  assign o_game_over   = r_game_over;

endmodule
